// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - time-multiplexed seven-segment scan driver with frame shadow
//
// Purpose:
//   Scans DIGITS active-low segment codes onto one shared segment bus plus
//   per-digit anode enables. Each digit gets a BLANK gap (all anodes off,
//   bus 8'hFF) followed by a SHOW period. All codes are snapshotted into a
//   shadow register once per frame, as digit 0 enters SHOW. This prevents
//   the display from tearing.
//
// Optional feature:
//   SEG_SCAN_DIM_EN - when defined, adds a 4-bit brightness input and a
//   PWM gate on the anode during SHOW. When undefined, SHOW is always full-on.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous, active-high reset
//   segs_in      in   [DIGITS-1:0][7:0] active-low segment codes, index 0 = rightmost
//   brightness   in   [3:0] duty level 0..15 (SEG_SCAN_DIM_EN only)
//   seg_out      out  [7:0] shared segment bus, active-low, 8'hFF = all off
//   an_out       out  [DIGITS-1:0] anode enables, polarity set by ACTIVE_LOW_AN
//   frame_start  out  one-cycle pulse on the first SHOW cycle of digit 0

module seg_scan #(
  parameter int DIGITS        = 8,
  parameter int DWELL_CYCLES  = 50000,
  parameter int BLANK_CYCLES  = 16,
  parameter bit ACTIVE_LOW_AN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIGITS-1:0][7:0] segs_in,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]             brightness,
`endif
  output logic [7:0]             seg_out,
  output logic [DIGITS-1:0]      an_out,
  output logic                   frame_start
);

  // One shared phase counter serves both states, so it is sized for the
  // longer of the two periods.
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF     = ACTIVE_LOW_AN ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DIGITS-1:0][7:0]   shadow_q, shadow_d;
  logic [7:0]               seg_out_q, seg_out_d;
  logic [DIGITS-1:0]        an_out_q, an_out_d;
  logic                     frame_start_q, frame_start_d;
  logic                     snap;
  logic                     lit_d;
  logic [DIGITS-1:0]        an_hot;

`ifdef SEG_SCAN_DIM_EN
  logic [3:0]               pwm_q, pwm_d;
  logic [3:0]               bri_q, bri_d;
`endif

  // State register and output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= {DIGITS{8'hFF}};
      seg_out_q     <= 8'hFF;
      an_out_q      <= AN_OFF;
      frame_start_q <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
      pwm_q         <= 4'h0;
      bri_q         <= 4'hF;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      seg_out_q     <= seg_out_d;
      an_out_q      <= an_out_d;
      frame_start_q <= frame_start_d;
`ifdef SEG_SCAN_DIM_EN
      pwm_q         <= pwm_d;
      bri_q         <= bri_d;
`endif
    end
  end

  // Next-state and registered-output logic. The output flops are loaded
  // from the *next* state, so the bus and anodes line up with the state
  // register in the same cycle. The outputs still come only from flops.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    snap     = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          // Leaving the gap in front of digit 0 marks a new frame.
          snap    = (idx_q == '0);
        end
      end
      ST_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (snap) begin
      shadow_d = segs_in;
    end

`ifdef SEG_SCAN_DIM_EN
    bri_d = bri_q;
    if (snap) begin
      bri_d = brightness;
    end
    // The PWM counter restarts on every BLANK->SHOW entry, so each digit
    // sees the same duty pattern from the start of its dwell.
    pwm_d = pwm_q;
    if (state_d == ST_SHOW) begin
      pwm_d = (state_q == ST_BLANK) ? 4'h0 : pwm_q + 4'h1;
    end
    lit_d = (state_d == ST_SHOW) && ((bri_d == 4'hF) || (pwm_d < bri_d));
`else
    lit_d = (state_d == ST_SHOW);
`endif

    an_hot        = lit_d ? ({{(DIGITS-1){1'b0}}, 1'b1} << idx_d) : '0;
    an_out_d      = ACTIVE_LOW_AN ? ~an_hot : an_hot;
    seg_out_d     = lit_d ? shadow_d[idx_d] : 8'hFF;
    frame_start_d = snap;
  end

  assign seg_out     = seg_out_q;
  assign an_out      = an_out_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan against a frame-position model
module tb_seg_scan;

  localparam int DIGITS = 8;
  localparam int BLANK  = 2;
`ifdef SEG_SCAN_DIM_EN
  localparam int DWELL  = 16;
`else
  localparam int DWELL  = 4;
`endif
  localparam int P      = BLANK + DWELL;
  localparam int FRAME  = DIGITS * P;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DIGITS-1:0][7:0] segs_in;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]             brightness;
`endif
  logic [7:0]             seg_out;
  logic [DIGITS-1:0]      an_out;
  logic                   frame_start;

  seg_scan #(
    .DIGITS        (DIGITS),
    .DWELL_CYCLES  (DWELL),
    .BLANK_CYCLES  (BLANK),
    .ACTIVE_LOW_AN (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .segs_in     (segs_in),
`ifdef SEG_SCAN_DIM_EN
    .brightness  (brightness),
`endif
    .seg_out     (seg_out),
    .an_out      (an_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: t counts cycles since the last reset edge.
  int                     t = 0;
  int                     cyc = 0;
  int                     last_fs = -1;
  logic [DIGITS-1:0][7:0] m_shadow;
  logic [7:0]             prev_an = 8'hFF;
  int                     lit_cnt = 0;
`ifdef SEG_SCAN_DIM_EN
  int                     m_bri = 15;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: apply rst, advance the model at the edge, compare at negedge.
  task automatic step(input logic r);
    int   pos;
    int   dig;
    int   ph;
    logic lit;
    logic [7:0] exp_seg;
    logic [7:0] exp_an;
    logic       exp_fs;
    rst = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      t        = 0;
      m_shadow = {DIGITS{8'hFF}};
      last_fs  = -1;
`ifdef SEG_SCAN_DIM_EN
      m_bri    = 15;
`endif
    end else begin
      t++;
      if ((t % FRAME) == BLANK) begin
        m_shadow = segs_in;
`ifdef SEG_SCAN_DIM_EN
        m_bri    = int'(brightness);
`endif
      end
    end
    @(negedge clk);
    pos = r ? 0 : (t % FRAME);
    dig = pos / P;
    ph  = pos % P;
    lit = (!r) && (ph >= BLANK);
`ifdef SEG_SCAN_DIM_EN
    if (lit && !((m_bri == 15) || (((ph - BLANK) % 16) < m_bri))) lit = 1'b0;
`endif
    exp_seg = lit ? m_shadow[dig] : 8'hFF;
    exp_an  = lit ? ~(8'b1 << dig) : 8'hFF;
    exp_fs  = (!r) && (pos == BLANK);
    check("seg_out", 32'(seg_out), 32'(exp_seg));
    check("an_out", 32'(an_out), 32'(exp_an));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    check("an_onehot", 32'($countones(~an_out) <= 1), 32'd1);
    if (prev_an != 8'hFF && an_out != 8'hFF) check("an_gap", 32'(an_out), 32'(prev_an));
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) check("fs_period", 32'(cyc - last_fs), 32'(FRAME));
      last_fs = cyc;
    end
    if (an_out != 8'hFF) lit_cnt++;
    prev_an = an_out;
  endtask

  // Step until the model reaches frame position target (at least one step).
  task automatic run_to(input int target, input string tag);
    int n;
    n = 0;
    do begin
      step(1'b0);
      n++;
    end while ((t % FRAME) != target && n < 2 * FRAME);
    check(tag, 32'(t % FRAME), 32'(target));
  endtask

  initial begin
    for (int k = 0; k < DIGITS; k++) segs_in[k] = 8'hC0 + 8'(k);
`ifdef SEG_SCAN_DIM_EN
    brightness = 4'hF;
`endif
    m_shadow = {DIGITS{8'hFF}};

    // Reset held 3 cycles, then first display.
    for (int i = 0; i < 3; i++) step(1'b1);
    check("rst_seg", 32'(seg_out), 32'hFF);
    check("rst_an", 32'(an_out), 32'hFF);
    check("rst_fs", 32'(frame_start), 32'h0);
    step(1'b0);
    check("blank2_an", 32'(an_out), 32'hFF);
    step(1'b0);
    check("first_an", 32'(an_out), 32'hFE);
    check("first_seg", 32'(seg_out), 32'hC0);
    check("first_fs", 32'(frame_start), 32'h1);
    step(1'b0);
    check("fs_one_cycle", 32'(frame_start), 32'h0);

    // Scan order over 100 cycles.
    for (int i = 0; i < 100; i++) step(1'b0);

    // Tear-free: change digit 5 while digit 2 is shown.
    run_to(2 * P + BLANK, "reach_d2");
    segs_in[5] = 8'h12;
    run_to(5 * P + BLANK, "reach_d5_cur");
    check("tear_cur", 32'(seg_out), 32'hC5);
    run_to(5 * P + BLANK, "reach_d5_next");
    check("tear_next", 32'(seg_out), 32'h12);

    // Reset for one cycle during digit 4 SHOW.
    run_to(4 * P + BLANK + 1, "reach_d4");
    step(1'b1);
    check("midrst_an", 32'(an_out), 32'hFF);
    check("midrst_seg", 32'(seg_out), 32'hFF);
    step(1'b0);
    step(1'b0);
    check("midrst_d0_an", 32'(an_out), 32'hFE);
    check("midrst_d0_fs", 32'(frame_start), 32'h1);
    for (int i = 0; i < FRAME; i++) step(1'b0);

`ifdef SEG_SCAN_DIM_EN
    // Brightness levels, one frame each, with mid-frame changes.
    brightness = 4'd4;
    run_to(BLANK, "dim4_sync");
    lit_cnt = (an_out != 8'hFF) ? 1 : 0;
    for (int i = 0; i < FRAME / 2; i++) step(1'b0);
    brightness = 4'd0;
    for (int i = 0; i < FRAME - 1 - FRAME / 2; i++) step(1'b0);
    check("dim4_lit", 32'(lit_cnt), 32'(DIGITS * 4));
    run_to(BLANK, "dim0_sync");
    lit_cnt = (an_out != 8'hFF) ? 1 : 0;
    brightness = 4'd15;
    for (int i = 0; i < FRAME - 1; i++) step(1'b0);
    check("dim0_lit", 32'(lit_cnt), 32'd0);
    run_to(BLANK, "dim15_sync");
    lit_cnt = (an_out != 8'hFF) ? 1 : 0;
    for (int i = 0; i < FRAME - 1; i++) step(1'b0);
    check("dim15_lit", 32'(lit_cnt), 32'(DIGITS * DWELL));
`endif

    // Randomized stimulus: code changes, occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) segs_in[$urandom_range(DIGITS - 1)] = 8'($urandom);
`ifdef SEG_SCAN_DIM_EN
      if ($urandom_range(63) == 0) brightness = 4'($urandom);
`endif
      step($urandom_range(299) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
